// File: rtl/fifo_pool_wc_pkg.sv
// Shared constants, hold-off state type and sizing helpers for the fifo_pool_wc buffer.
package fifo_pool_wc_pkg;

    localparam int unsigned DEF_DIN_W       = 32;
    localparam int unsigned DEF_DOUT_W      = 16;
    localparam int unsigned DEF_DEPTH       = 4096;
    localparam int unsigned DEF_AF_MARGIN   = 16;
    localparam int unsigned DEF_STARTUP_CYC = 16;
    localparam int unsigned ERRCNT_W        = 16;

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } hold_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        int unsigned p;
        r = 0;
        p = 1;
        while (p < v) begin
            p = p << 1;
            r = r + 1;
        end
        return r;
    endfunction

    // Lane index needs at least one bit even when a word holds a single lane.
    function automatic int unsigned lane_w(input int unsigned ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

    // Saturating error counter step; an increment coinciding with a clear leaves 1.
    function automatic logic [ERRCNT_W-1:0] sat_step(input logic [ERRCNT_W-1:0] cnt,
                                                     input logic inc, input logic clr);
        logic [ERRCNT_W-1:0] res;
        if (clr) begin
            res = inc ? ERRCNT_W'(1) : '0;
        end else if (inc && (cnt != '1)) begin
            res = cnt + ERRCNT_W'(1);
        end else begin
            res = cnt;
        end
        return res;
    endfunction

endpackage

// File: rtl/fifo_pool_wc_ram.sv
// Simple dual-port synchronous RAM, one write and one read port, 1-cycle read latency.
module fifo_pool_wc_ram
    import fifo_pool_wc_pkg::*;
#(
    parameter int unsigned W     = DEF_DIN_W,
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    // No reset on the array or output register so the tools map it onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_pool_wc.sv
// Width-converting packet buffer: DIN_W words in, DOUT_W lanes out, with hold-off and flags.
// Define FIFO_POOL_WC_ERRCNT_EN to add saturating drop_cnt / udf_cnt error counters.
module fifo_pool_wc
    import fifo_pool_wc_pkg::*;
#(
    parameter int unsigned DIN_W       = DEF_DIN_W,
    parameter int unsigned DOUT_W      = DEF_DOUT_W,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned AF_MARGIN   = DEF_AF_MARGIN,
    parameter int unsigned STARTUP_CYC = DEF_STARTUP_CYC
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            wr_en,
    input  logic [DIN_W-1:0]                                wr_data,
    output logic                                            wr_full,
    output logic                                            wr_almost_full,
    output logic                                            wr_ready,
    input  logic [clog2(DEPTH):0]                           pkt_thresh,
    output logic                                            packet_full,
    input  logic                                            lane_msb_first,
    input  logic                                            rd_en,
    output logic [DOUT_W-1:0]                               rd_data,
    output logic                                            rd_valid,
    output logic                                            rd_empty,
    output logic [clog2(DEPTH):0]                           wr_level,
    output logic [clog2(DEPTH)+clog2(DIN_W/DOUT_W):0]       rd_level,
    input  logic                                            clr_err,
    output logic                                            overflow,
    output logic                                            underflow
`ifdef FIFO_POOL_WC_ERRCNT_EN
    ,
    output logic [ERRCNT_W-1:0]                             drop_cnt,
    output logic [ERRCNT_W-1:0]                             udf_cnt
`endif
);

    localparam int unsigned RATIO = DIN_W / DOUT_W;
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned RB    = clog2(RATIO);
    localparam int unsigned RLW   = LW + RB;
    localparam int unsigned KW    = lane_w(RATIO);
    localparam int unsigned NLANE = 1 << KW;
    localparam int unsigned CW    = clog2(STARTUP_CYC + 1);

    hold_state_t     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ready_q, ready_d;

    logic [LW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [KW-1:0]   lane_q, lane_d;
    logic [LW-1:0]   level_q, level_d;
    logic [RLW-1:0]  rd_level_q, rd_level_d;
    logic            wr_full_q, wr_full_d;
    logic            wr_af_q, wr_af_d;
    logic            pkt_full_q, pkt_full_d;
    logic            rd_empty_q, rd_empty_d;
    logic            rd_valid_q, rd_valid_d;
    logic [KW-1:0]   sel_q, sel_d;
    logic            rd_any_q, rd_any_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;

    logic            wr_acc, wr_drop, rd_acc, rd_udf, last_lane;
    logic [31:0]     free_d;
    logic [DIN_W-1:0]  ram_rdata;
    logic [DOUT_W-1:0] lanes [NLANE];

    // Post-reset hold-off sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(STARTUP_CYC - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
    end

    assign ready_q = (state_q == ST_RUN);
    assign ready_d = (state_d == ST_RUN);

    // Pointers, lane index, levels and flags derived from next-state occupancy.
    always_comb begin
        wr_acc    = wr_en & ready_q & ~wr_full_q;
        wr_drop   = wr_en & ready_q & wr_full_q;
        rd_acc    = rd_en & ~rd_empty_q;
        rd_udf    = rd_en & ready_q & rd_empty_q;
        last_lane = (lane_q == KW'(RATIO - 1));

        wr_ptr_d  = wr_ptr_q + LW'(wr_acc);
        rd_ptr_d  = rd_ptr_q + LW'(rd_acc & last_lane);
        lane_d    = lane_q;
        if (rd_acc) begin
            lane_d = last_lane ? '0 : lane_q + KW'(1);
        end
        level_d    = wr_ptr_d - rd_ptr_d;
        rd_level_d = (RLW'(level_d) << RB) - RLW'(lane_d);
        free_d     = DEPTH - 32'(level_d);

        wr_full_d  = ~ready_d | (level_d == LW'(DEPTH));
        wr_af_d    = ~ready_d | (free_d <= AF_MARGIN);
        pkt_full_d = ready_d & (level_d >= pkt_thresh);
        rd_empty_d = ~ready_d | (rd_level_d == '0);

        rd_valid_d = rd_acc;
        rd_any_d   = rd_any_q | rd_acc;
        sel_d      = sel_q;
        if (rd_acc) begin
            sel_d = lane_msb_first ? (KW'(RATIO - 1) - lane_q) : lane_q;
        end

        ovf_d = wr_drop | (ovf_q & ~clr_err);
        udf_d = rd_udf | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lane_q     <= '0;
            level_q    <= '0;
            rd_level_q <= '0;
            wr_full_q  <= 1'b1;
            wr_af_q    <= 1'b1;
            pkt_full_q <= 1'b0;
            rd_empty_q <= 1'b1;
            rd_valid_q <= 1'b0;
            sel_q      <= '0;
            rd_any_q   <= 1'b0;
            ovf_q      <= 1'b0;
            udf_q      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            level_q    <= level_d;
            rd_level_q <= rd_level_d;
            wr_full_q  <= wr_full_d;
            wr_af_q    <= wr_af_d;
            pkt_full_q <= pkt_full_d;
            rd_empty_q <= rd_empty_d;
            rd_valid_q <= rd_valid_d;
            sel_q      <= sel_d;
            rd_any_q   <= rd_any_d;
            ovf_q      <= ovf_d;
            udf_q      <= udf_d;
        end
    end

    fifo_pool_wc_ram #(
        .W     (DIN_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr_q[AW-1:0]),
        .rd_data (ram_rdata)
    );

    // Lane mux over the RAM output register; lane chosen when the read was accepted.
    for (genvar g = 0; g < NLANE; g++) begin : g_lane
        if (g < RATIO) begin : g_used
            assign lanes[g] = ram_rdata[g*DOUT_W +: DOUT_W];
        end else begin : g_pad
            assign lanes[g] = '0;
        end
    end

    assign rd_data        = rd_any_q ? lanes[sel_q] : '0;
    assign rd_valid       = rd_valid_q;
    assign rd_empty       = rd_empty_q;
    assign wr_full        = wr_full_q;
    assign wr_almost_full = wr_af_q;
    assign wr_ready       = ready_q;
    assign packet_full    = pkt_full_q;
    assign wr_level       = level_q;
    assign rd_level       = rd_level_q;
    assign overflow       = ovf_q;
    assign underflow      = udf_q;

`ifdef FIFO_POOL_WC_ERRCNT_EN
    logic [ERRCNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [ERRCNT_W-1:0] udf_cnt_q, udf_cnt_d;

    always_comb begin
        drop_cnt_d = sat_step(drop_cnt_q, wr_drop, clr_err);
        udf_cnt_d  = sat_step(udf_cnt_q, rd_udf, clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            udf_cnt_q  <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            udf_cnt_q  <= udf_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign udf_cnt  = udf_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_pool_wc.sv
// Directed bench for fifo_pool_wc: a 256-deep instance and a 16-deep instance (AF_MARGIN=4).
module tb_fifo_pool_wc;

    logic clk;
    int   checks   = 0;
    int   failures = 0;

    // 256-deep instance
    logic        b_rst_n, b_wr_en, b_rd_en, b_msb, b_clr;
    logic [31:0] b_wr_data;
    logic [8:0]  b_thresh;
    logic        b_full, b_af, b_ready, b_pkt, b_valid, b_empty, b_ovf, b_udf;
    logic [15:0] b_rd_data;
    logic [8:0]  b_level;
    logic [9:0]  b_rd_level;

    // 16-deep instance
    logic        s_rst_n, s_wr_en, s_rd_en, s_msb, s_clr;
    logic [31:0] s_wr_data;
    logic [4:0]  s_thresh;
    logic        s_full, s_af, s_ready, s_pkt, s_valid, s_empty, s_ovf, s_udf;
    logic [15:0] s_rd_data;
    logic [4:0]  s_level;
    logic [5:0]  s_rd_level;

`ifdef FIFO_POOL_WC_ERRCNT_EN
    logic [15:0] b_drop_cnt, b_udf_cnt, s_drop_cnt, s_udf_cnt;
`endif

    fifo_pool_wc #(.DIN_W(32), .DOUT_W(16), .DEPTH(256), .AF_MARGIN(16), .STARTUP_CYC(16)) u_big (
        .clk(clk), .rst_n(b_rst_n), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .wr_full(b_full), .wr_almost_full(b_af), .wr_ready(b_ready),
        .pkt_thresh(b_thresh), .packet_full(b_pkt), .lane_msb_first(b_msb),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_valid), .rd_empty(b_empty),
        .wr_level(b_level), .rd_level(b_rd_level), .clr_err(b_clr),
        .overflow(b_ovf), .underflow(b_udf)
`ifdef FIFO_POOL_WC_ERRCNT_EN
        , .drop_cnt(b_drop_cnt), .udf_cnt(b_udf_cnt)
`endif
    );

    fifo_pool_wc #(.DIN_W(32), .DOUT_W(16), .DEPTH(16), .AF_MARGIN(4), .STARTUP_CYC(16)) u_small (
        .clk(clk), .rst_n(s_rst_n), .wr_en(s_wr_en), .wr_data(s_wr_data),
        .wr_full(s_full), .wr_almost_full(s_af), .wr_ready(s_ready),
        .pkt_thresh(s_thresh), .packet_full(s_pkt), .lane_msb_first(s_msb),
        .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_valid), .rd_empty(s_empty),
        .wr_level(s_level), .rd_level(s_rd_level), .clr_err(s_clr),
        .overflow(s_ovf), .underflow(s_udf)
`ifdef FIFO_POOL_WC_ERRCNT_EN
        , .drop_cnt(s_drop_cnt), .udf_cnt(s_udf_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        b_rst_n = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; b_msb = 1'b1; b_clr = 1'b0;
        b_wr_data = '0; b_thresh = 9'd0;
        s_rst_n = 1'b0; s_wr_en = 1'b0; s_rd_en = 1'b0; s_msb = 1'b1; s_clr = 1'b0;
        s_wr_data = '0; s_thresh = 5'd17;
        tick();
        tick();

        // Reset state
        chk("rst_full",   32'(b_full), 32'd1);
        chk("rst_af",     32'(b_af), 32'd1);
        chk("rst_empty",  32'(b_empty), 32'd1);
        chk("rst_ready",  32'(b_ready), 32'd0);
        chk("rst_pkt",    32'(b_pkt), 32'd0);
        chk("rst_level",  32'(b_level), 32'd0);
        chk("rst_rdlvl",  32'(b_rd_level), 32'd0);
        chk("rst_rddata", 32'(b_rd_data), 32'd0);
        chk("rst_valid",  32'(b_valid), 32'd0);
        chk("rst_ovf",    32'(b_ovf), 32'd0);

        // Hold-off: writes and reads presented during cycles 1..16 are ignored
        b_rst_n = 1'b1; s_rst_n = 1'b1;
        b_wr_en = 1'b1; b_wr_data = 32'h1111_2222; b_rd_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                chk("hold_ready15", 32'(b_ready), 32'd0);
                chk("hold_full15",  32'(b_full), 32'd1);
                chk("hold_empty15", 32'(b_empty), 32'd1);
            end
        end
        b_wr_en = 1'b0; b_rd_en = 1'b0; b_thresh = 9'd139;
        chk("hold_ready16", 32'(b_ready), 32'd1);
        chk("hold_level",   32'(b_level), 32'd0);
        chk("hold_full16",  32'(b_full), 32'd0);
        chk("hold_af16",    32'(b_af), 32'd0);
        chk("hold_empty16", 32'(b_empty), 32'd1);
        chk("hold_ovf",     32'(b_ovf), 32'd0);
        chk("hold_udf",     32'(b_udf), 32'd0);
        chk("hold_pkt_t0",  32'(b_pkt), 32'd1);

        // Lane order, upper lane first
        b_msb = 1'b1; b_wr_en = 1'b1; b_wr_data = 32'hAAAA_BBBB;
        tick();
        b_wr_en = 1'b0;
        chk("lane_level1", 32'(b_level), 32'd1);
        chk("lane_rdlvl2", 32'(b_rd_level), 32'd2);
        chk("lane_empty0", 32'(b_empty), 32'd0);
        chk("lane_pkt139", 32'(b_pkt), 32'd0);
        b_rd_en = 1'b1;
        tick();
        chk("msb_lane0",  32'(b_rd_data), 32'hAAAA);
        chk("msb_valid0", 32'(b_valid), 32'd1);
        chk("msb_rdlvl",  32'(b_rd_level), 32'd1);
        tick();
        b_rd_en = 1'b0;
        chk("msb_lane1",  32'(b_rd_data), 32'hBBBB);
        chk("msb_level0", 32'(b_level), 32'd0);
        chk("msb_empty",  32'(b_empty), 32'd1);
        tick();
        chk("hold_rddata", 32'(b_rd_data), 32'hBBBB);
        chk("idle_valid",  32'(b_valid), 32'd0);

        // Lane order, lower lane first
        b_msb = 1'b0; b_wr_en = 1'b1; b_wr_data = 32'hAAAA_BBBB;
        tick();
        b_wr_en = 1'b0; b_rd_en = 1'b1;
        tick();
        chk("lsb_lane0", 32'(b_rd_data), 32'hBBBB);
        tick();
        b_rd_en = 1'b0;
        chk("lsb_lane1",  32'(b_rd_data), 32'hAAAA);
        chk("lsb_level0", 32'(b_level), 32'd0);

        // Packet threshold at 139 words
        b_wr_en = 1'b1;
        for (int i = 0; i < 138; i++) begin
            b_wr_data = {16'(16'hC000 + i), 16'(16'h5000 + i)};
            tick();
        end
        b_wr_en = 1'b0;
        chk("thr_level138", 32'(b_level), 32'd138);
        chk("thr_pkt138",   32'(b_pkt), 32'd0);
        chk("thr_af138",    32'(b_af), 32'd0);
        b_wr_en = 1'b1; b_wr_data = 32'h1234_5678;
        tick();
        b_wr_en = 1'b0;
        chk("thr_pkt139",   32'(b_pkt), 32'd1);
        chk("thr_rdlvl139", 32'(b_rd_level), 32'd278);
        b_rd_en = 1'b1;
        tick();
        chk("thr_lane0", 32'(b_rd_data), 32'h5000);
        tick();
        b_rd_en = 1'b0;
        chk("thr_lane1",   32'(b_rd_data), 32'hC000);
        chk("thr_pkt_rd",  32'(b_pkt), 32'd0);
        chk("thr_level_rd", 32'(b_level), 32'd138);

        // Small instance: almost-full, full, overflow, clear
        s_msb = 1'b1; s_wr_en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            s_wr_data = {16'(16'h1000 + i), 16'(16'h2000 + i)};
            tick();
        end
        chk("af_11", 32'(s_af), 32'd0);
        s_wr_data = {16'h100B, 16'h200B};
        tick();
        chk("af_12",   32'(s_af), 32'd1);
        chk("full_12", 32'(s_full), 32'd0);
        for (int i = 12; i < 16; i++) begin
            s_wr_data = {16'(16'h1000 + i), 16'(16'h2000 + i)};
            tick();
        end
        chk("full_16",  32'(s_full), 32'd1);
        chk("level_16", 32'(s_level), 32'd16);
        chk("rdlvl_16", 32'(s_rd_level), 32'd32);
        chk("pkt_gt_depth", 32'(s_pkt), 32'd0);
        s_wr_data = 32'hDEAD_DEAD;
        tick();
        s_wr_en = 1'b0;
        chk("ovf_set",   32'(s_ovf), 32'd1);
        chk("ovf_level", 32'(s_level), 32'd16);
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        chk("ovf_clr", 32'(s_ovf), 32'd0);

        // Full: write with final-lane read is rejected; later write with final-lane read keeps level
        s_rd_en = 1'b1;
        tick();
        chk("sim_lane0", 32'(s_rd_data), 32'h1000);
        s_wr_en = 1'b1; s_wr_data = 32'hBEEF_BEEF;
        tick();
        s_wr_en = 1'b0;
        chk("sim_rej_level", 32'(s_level), 32'd15);
        chk("sim_rej_data",  32'(s_rd_data), 32'h2000);
        chk("sim_rej_ovf",   32'(s_ovf), 32'd1);
        chk("sim_rej_full",  32'(s_full), 32'd0);
        tick();
        chk("sim_w1_lane0", 32'(s_rd_data), 32'h1001);
        s_wr_en = 1'b1; s_wr_data = {16'h1010, 16'h2010};
        tick();
        s_wr_en = 1'b0; s_rd_en = 1'b0;
        chk("sim_keep_level", 32'(s_level), 32'd15);
        chk("sim_keep_rdlvl", 32'(s_rd_level), 32'd30);
        chk("sim_w1_lane1",   32'(s_rd_data), 32'h2001);
`ifdef FIFO_POOL_WC_ERRCNT_EN
        chk("drop_cnt", 32'(s_drop_cnt), 32'd1);
`endif

        // Drain and underflow
        s_rd_en = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        s_rd_en = 1'b0;
        chk("drain_last",  32'(s_rd_data), 32'h2010);
        chk("drain_empty", 32'(s_empty), 32'd1);
        chk("drain_level", 32'(s_level), 32'd0);
        s_rd_en = 1'b1;
        tick();
        chk("udf_set",   32'(s_udf), 32'd1);
        chk("udf_valid", 32'(s_valid), 32'd0);
        chk("udf_data",  32'(s_rd_data), 32'h2010);
        s_clr = 1'b1;
        tick();
        s_rd_en = 1'b0;
        chk("udf_set_wins", 32'(s_udf), 32'd1);
`ifdef FIFO_POOL_WC_ERRCNT_EN
        chk("udf_cnt_clr_inc", 32'(s_udf_cnt), 32'd1);
`endif
        tick();
        s_clr = 1'b0;
        chk("udf_clr", 32'(s_udf), 32'd0);

        // Reset mid-operation with 5 words stored
        s_wr_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_wr_data = 32'(i);
            tick();
        end
        s_wr_en = 1'b0;
        chk("mid_level5", 32'(s_level), 32'd5);
        s_rst_n = 1'b0;
        #1;
        chk("mid_level0", 32'(s_level), 32'd0);
        chk("mid_empty",  32'(s_empty), 32'd1);
        chk("mid_ready",  32'(s_ready), 32'd0);
        chk("mid_full",   32'(s_full), 32'd1);
        tick();
        s_rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("mid_hold15", 32'(s_ready), 32'd0);
        end
        chk("mid_hold16",  32'(s_ready), 32'd1);
        chk("mid_empty16", 32'(s_empty), 32'd1);
        chk("mid_rdlvl",   32'(s_rd_level), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_pool_wc.md
Name: fifo_pool_wc

Overview:
- Parametrised, single-clock, width-converting packet buffer. Successor to the 32-to-16 FIFO pool on the Aurora data path.
- Accepts DIN_W-bit words from the event/packet builder and stores up to DEPTH words.
- Emits DOUT_W-bit lanes toward the fiber/DMA reader, with selectable lane order.
- Provides a runtime-programmable packet-ready threshold, a post-reset hold-off, occupancy levels and sticky error flags.

Parameters:
- DIN_W, 32, input word width; must equal DOUT_W*RATIO with RATIO a power of 2 ≥ 1.
- DOUT_W, 16, output lane width.
- DEPTH, 4096, storage depth in input words; power of 2.
- AF_MARGIN, 16, wr_almost_full asserts when free input-word slots ≤ AF_MARGIN.
- STARTUP_CYC, 16, hold-off cycles after reset release; must be ≥ 1.

Ports:
- clk, in, 1, single clock for all logic.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, write strobe.
- wr_data, in, DIN_W, write word.
- wr_full, out, 1, no free word slot or in hold-off.
- wr_almost_full, out, 1, margin reached or in hold-off.
- wr_ready, out, 1, hold-off complete.
- pkt_thresh, in, AW+1 (AW=clog2(DEPTH)), packet threshold in input words.
- packet_full, out, 1, stored words ≥ pkt_thresh.
- lane_msb_first, in, 1, 1 = upper lane of each word is output first.
- rd_en, in, 1, read strobe.
- rd_data, out, DOUT_W, read lane.
- rd_valid, out, 1, rd_data valid this cycle.
- rd_empty, out, 1, no lane available.
- wr_level, out, AW+1, stored input words.
- rd_level, out, AW+1+clog2(RATIO), available output lanes.
- clr_err, in, 1, clears the sticky flags.
- overflow, out, 1, sticky: write dropped.
- underflow, out, 1, sticky: read while empty.

Behaviour:
- **Reset (rst_n=0):** pointers, lane index, levels, rd_data, rd_valid, overflow and underflow go to 0. wr_full=1, wr_almost_full=1, rd_empty=1, wr_ready=0, packet_full=0. Storage contents are undefined.
- **Hold-off:** after rst_n rises, a counter runs STARTUP_CYC cycles. During hold-off:
  - wr_full and wr_almost_full are forced 1, rd_empty is forced 1, wr_ready=0.
  - wr_en and rd_en are ignored, with no error flags.
  - wr_ready rises on cycle STARTUP_CYC+1 after release.
- **Write:** accepted when wr_en=1, wr_ready=1 and registered wr_full=0. Otherwise, if wr_ready=1, the word is dropped and overflow sets.
  - Data becomes visible to the read side on the next cycle; rd_empty deasserts one cycle after the first accepted write.
- **Read:** accepted when rd_en=1 and rd_empty=0. rd_data and rd_valid appear exactly 1 cycle later.
  - rd_en while rd_empty=1 (after hold-off) sets underflow; rd_valid stays 0.
  - rd_data holds its last value when rd_valid=0.
- **Lane sequencing:** lane index k runs 0..RATIO-1 within the head word.
  - lane_msb_first=1: lane k = wr_data[DIN_W-1-k*DOUT_W -: DOUT_W].
  - lane_msb_first=0: lane k = wr_data[k*DOUT_W +: DOUT_W].
  - The head word slot is freed only when lane RATIO-1 is read; the index then wraps to 0.
  - lane_msb_first is quasi-static. A change mid-word takes effect from the next lane read.
  - RATIO=1 degenerates to a plain FIFO.
- **Levels:** rd_level = wr_level*RATIO − k.
  - wr_full, wr_almost_full and packet_full are registered from next-state wr_level, so they are exact on the cycle after the causing event.
  - Simultaneous accepted write and final-lane read leaves wr_level unchanged.
  - A write presented while full is rejected even if the final lane is read in the same cycle.
- **packet_full:** (wr_level ≥ pkt_thresh) and wr_ready.
  - pkt_thresh=0 makes packet_full=1 after hold-off.
  - pkt_thresh>DEPTH makes packet_full never assert.
- **Pointers:** wrap modulo DEPTH. Occupancy uses an extra MSB to tell full from empty.
- **clr_err:** clears overflow and underflow. If an error occurs in the same cycle, the set wins.
- **Reset mid-operation:** all stored data is discarded and hold-off restarts.

Optional Feature:
- Macro FIFO_POOL_WC_ERRCNT_EN.
- Defined: adds outputs drop_cnt[15:0] and udf_cnt[15:0]. They count dropped writes and empty reads, saturate at 16'hFFFF, reset to 0, and are cleared by clr_err. Increment and clear in the same cycle gives 1.
- Undefined: the ports are absent; only the sticky flags exist.

Decomposition:
- Package fifo_pool_wc_pkg holds:
  - the clog2 constant function;
  - constants for the default widths and depth;
  - a lane-index width helper.
- Sub-module fifo_pool_wc_ram: simple dual-port synchronous RAM, DIN_W x DEPTH, 1-cycle read latency, inferred as block RAM.
- The control FSM, pointers, lane mux and flags stay in the top module.

Test Plan:
- Hold-off: release rst_n, drive wr_en=1 with data 0x11112222 for cycles 1–16 → nothing stored; overflow=0; wr_ready rises on cycle 17; rd_empty stays 1.
- Lane order: write 0xAAAABBBB with lane_msb_first=1, read 2 lanes → 0xAAAA then 0xBBBB. Repeat with lane_msb_first=0 → 0xBBBB then 0xAAAA. wr_level returns to 0 after lane 2.
- Threshold: pkt_thresh=139; write 138 words → packet_full=0; the 139th write → packet_full=1 next cycle; read 2 lanes → packet_full=0.
- Full/overflow: with DEPTH=16 and AF_MARGIN=4, write 12 words → wr_almost_full=1; write 4 more → wr_full=1; a 17th write is dropped and overflow=1; clr_err → overflow=0.
- Simultaneous: hold full, then present wr_en together with the final-lane rd_en → write rejected, wr_level=15. Next cycle, write plus final-lane read → wr_level stays 15.
- Underflow and mid-reset: rd_en while empty → underflow=1, rd_valid=0. Pulse rst_n low with 5 words stored → rd_empty=1, wr_level=0, hold-off repeats.
